// File: rtl/cv32e40x_aes_prot_pkg.sv
// ----------------------------------------------------------------------------
// cv32e40x_aes_prot_pkg
//   Shared types and constants for the masked saes32 sequencing controller:
//   controller state encoding, AES op kind encoding, latched operand bundle,
//   RNG word field widths and the op-kind to one-hot decode helper.
// ----------------------------------------------------------------------------
package cv32e40x_aes_prot_pkg;

   localparam int RNG_SHAREB_W = 8;
   localparam int RNG_RAND_W   = 36;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RNG   = 3'd1,
      EXEC  = 3'd2,
      DONE  = 3'd3,
      SCRUB = 3'd4
   } aes_prot_state_e;

   typedef enum logic [1:0] {
      ENCS  = 2'd0,
      ENCSM = 2'd1,
      DECS  = 2'd2,
      DECSM = 2'd3
   } aes_op_kind_e;

   // Operands captured at op accept and held for the whole operation
   typedef struct packed {
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [1:0]  bs;
      logic [3:0]  op;   // one-hot {decsm, decs, encsm, encs}
   } aes_op_req_t;

   function automatic logic [3:0] aes_op_onehot(input aes_op_kind_e kind);
      logic [3:0] oh;
      oh = 4'b0000;
      case (kind)
         ENCS:    oh = 4'b0001;
         ENCSM:   oh = 4'b0010;
         DECS:    oh = 4'b0100;
         DECSM:   oh = 4'b1000;
         default: oh = 4'b0000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/cv32e40x_aes_prot_ctrl.sv
// ----------------------------------------------------------------------------
// cv32e40x_aes_prot_ctrl
//   Sequences one masked saes32 operation at a time: accept op from execute,
//   fetch a fresh RNG word, hold the unit inputs stable while the DOM S-box
//   settles, capture the result and hand it back with valid/ready.
//
// Optional build macro: CV32E40X_AES_PROT_SCRUB_EN
//   When defined, every completed or killed op passes through one SCRUB cycle
//   that zeroes operand, randomness and result registers before IDLE.
//
// Ports
//   clk, reset                 core clock, synchronous active-high reset
//   op_valid_i / op_ready_o    op handshake from execute (ready only in IDLE)
//   op_kind_i, rs1_i, rs2_i,   op kind (encs/encsm/decs/decsm) and operands
//   bs_i
//   kill_i                     flush of the in-flight op
//   rng_req_o / rng_valid_i,   randomness request and returned word
//   rng_data_i                 ([7:0] shareB, [43:8] randombits)
//   fu_*_o, fu_valid_o         registered, stable inputs to the masked unit
//   fu_rd_i                    unit result
//   res_valid_o / res_ready_i, result handshake and registered result
//   res_rd_o
// ----------------------------------------------------------------------------
module cv32e40x_aes_prot_ctrl
   import cv32e40x_aes_prot_pkg::*;
#(
   parameter int SBOX_LAT = 2,
   parameter int RNG_W    = 44
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    op_valid_i,
   output logic                    op_ready_o,
   input  logic [1:0]              op_kind_i,
   input  logic [31:0]             rs1_i,
   input  logic [31:0]             rs2_i,
   input  logic [1:0]              bs_i,
   input  logic                    kill_i,
   output logic                    rng_req_o,
   input  logic                    rng_valid_i,
   input  logic [RNG_W-1:0]        rng_data_i,
   output logic [31:0]             fu_rs1_o,
   output logic [31:0]             fu_rs2_o,
   output logic [1:0]              fu_bs_o,
   output logic [RNG_SHAREB_W-1:0] fu_shareB_o,
   output logic [RNG_RAND_W-1:0]   fu_rand_o,
   output logic [3:0]              fu_op_o,
   output logic                    fu_valid_o,
   input  logic [31:0]             fu_rd_i,
   output logic                    res_valid_o,
   input  logic                    res_ready_i,
   output logic [31:0]             res_rd_o
);

   localparam int               CNT_W    = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SBOX_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef CV32E40X_AES_PROT_SCRUB_EN
   localparam aes_prot_state_e END_ST = SCRUB;
`else
   localparam aes_prot_state_e END_ST = IDLE;
`endif

   aes_prot_state_e          state_q, state_d;
   aes_op_req_t              req_q, req_d;
   logic [RNG_SHAREB_W-1:0]  shareb_q, shareb_d;
   logic [RNG_RAND_W-1:0]    rand_q, rand_d;
   logic [31:0]              res_q, res_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         req_q    <= '0;
         shareb_q <= '0;
         rand_q   <= '0;
         res_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         shareb_q <= shareb_d;
         rand_q   <= rand_d;
         res_q    <= res_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      shareb_d = shareb_q;
      rand_d   = rand_q;
      res_d    = res_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (op_valid_i) begin
               req_d.rs1 = rs1_i;
               req_d.rs2 = rs2_i;
               req_d.bs  = bs_i;
               req_d.op  = aes_op_onehot(aes_op_kind_e'(op_kind_i));
               state_d   = RNG;
            end
         end
         RNG: begin
            // kill beats a same-cycle RNG word: the word is dropped unused
            if (kill_i) begin
               state_d = END_ST;
            end else if (rng_valid_i) begin
               shareb_d = rng_data_i[RNG_SHAREB_W-1:0];
               rand_d   = rng_data_i[RNG_SHAREB_W +: RNG_RAND_W];
               cnt_d    = CNT_LOAD;
               state_d  = EXEC;
            end
         end
         EXEC: begin
            // The RNG-hit cycle counts toward the latency, so capture in the
            // cycle where the decrement would reach zero.
            if (kill_i) begin
               state_d = END_ST;
            end else if (cnt_q <= CNT_ONE) begin
               cnt_d   = '0;
               res_d   = fu_rd_i;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         DONE: begin
            if (kill_i || res_ready_i) state_d = END_ST;
         end
`ifdef CV32E40X_AES_PROT_SCRUB_EN
         SCRUB: begin
            // No unmasked operand, mask or result survives the op
            req_d.rs1 = '0;
            req_d.rs2 = '0;
            shareb_d  = '0;
            rand_d    = '0;
            res_d     = '0;
            state_d   = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   assign op_ready_o  = (state_q == IDLE);
   assign rng_req_o   = (state_q == RNG);
   assign fu_valid_o  = (state_q == EXEC);
   assign res_valid_o = (state_q == DONE);

   assign fu_rs1_o    = req_q.rs1;
   assign fu_rs2_o    = req_q.rs2;
   assign fu_bs_o     = req_q.bs;
   assign fu_op_o     = req_q.op;
   assign fu_shareB_o = shareb_q;
   assign fu_rand_o   = rand_q;
   assign res_rd_o    = res_q;

endmodule

// File: tb/tb_cv32e40x_aes_prot_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cv32e40x_aes_prot_ctrl
//   Directed bench for the saes32 sequencing controller. The masked unit is a
//   stub whose result is a fixed function of the held inputs (and a poison
//   value whenever fu_valid_o is low), so captured results are predictable.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cv32e40x_aes_prot_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid_i, op_ready_o;
   logic [1:0]  op_kind_i;
   logic [31:0] rs1_i, rs2_i;
   logic [1:0]  bs_i;
   logic        kill_i;
   logic        rng_req_o, rng_valid_i;
   logic [43:0] rng_data_i;
   logic [31:0] fu_rs1_o, fu_rs2_o;
   logic [1:0]  fu_bs_o;
   logic [7:0]  fu_shareB_o;
   logic [35:0] fu_rand_o;
   logic [3:0]  fu_op_o;
   logic        fu_valid_o;
   logic [31:0] fu_rd_i;
   logic        res_valid_o, res_ready_i;
   logic [31:0] res_rd_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cv32e40x_aes_prot_ctrl #(.SBOX_LAT(2), .RNG_W(44)) dut (
      .clk(clk), .reset(reset),
      .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_kind_i(op_kind_i),
      .rs1_i(rs1_i), .rs2_i(rs2_i), .bs_i(bs_i), .kill_i(kill_i),
      .rng_req_o(rng_req_o), .rng_valid_i(rng_valid_i), .rng_data_i(rng_data_i),
      .fu_rs1_o(fu_rs1_o), .fu_rs2_o(fu_rs2_o), .fu_bs_o(fu_bs_o),
      .fu_shareB_o(fu_shareB_o), .fu_rand_o(fu_rand_o), .fu_op_o(fu_op_o),
      .fu_valid_o(fu_valid_o), .fu_rd_i(fu_rd_i),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_rd_o(res_rd_o)
   );

   // Unit stub: encsm of byte 0x53 gives the reference word, anything else a
   // simple mix of the held inputs.
   function automatic logic [31:0] fu_stub(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [1:0] bs);
      if (op == 4'b0010 && b[7:0] == 8'h53 && bs == 2'd0) return 32'hED76769B ^ a;
      return a ^ {b[15:0], b[31:16]} ^ {26'd0, bs, op};
   endfunction

   always_comb fu_rd_i = fu_valid_o ? fu_stub(fu_op_o, fu_rs1_o, fu_rs2_o, fu_bs_o)
                                    : 32'hBAD0BAD0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h @%0t", tag, obs, exp, $time);
      end
   endtask

   // advance one clock; outputs are then sampled 1ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [1:0] kind, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] bs);
      op_valid_i = 1'b1; op_kind_i = kind; rs1_i = a; rs2_i = b; bs_i = bs;
   endtask

   // after a handshake or kill: optional scrub cycle, then back to IDLE
   task automatic post_end(input string tag);
`ifdef CV32E40X_AES_PROT_SCRUB_EN
      chk({tag, "_scrub_rdy"}, op_ready_o, 0);
      chk({tag, "_scrub_rs1"}, fu_rs1_o, 0);
      chk({tag, "_scrub_rs2"}, fu_rs2_o, 0);
      chk({tag, "_scrub_res"}, res_rd_o, 0);
      step();
`endif
      chk({tag, "_idle_rdy"}, op_ready_o, 1);
   endtask

   // Full op with an immediate RNG word: accept at cycle 0, res_valid at 3
   task automatic run_op(input string tag, input logic [1:0] kind, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] bs,
                         input logic [43:0] rw, input logic [3:0] exp_oh,
                         input logic [31:0] exp_rd);
      chk({tag, "_c0_rdy"}, op_ready_o, 1);
      present(kind, a, b, bs);
      rng_valid_i = 1'b1; rng_data_i = rw;
      step();                                         // cycle 1: RNG
      op_valid_i = 1'b0;
      chk({tag, "_c1_req"}, rng_req_o, 1);
      chk({tag, "_c1_rdy"}, op_ready_o, 0);
      step();                                         // cycle 2: EXEC
      rng_valid_i = 1'b0;
      chk({tag, "_c2_fuv"}, fu_valid_o, 1);
      chk({tag, "_c2_op"}, fu_op_o, exp_oh);
      chk({tag, "_c2_rs1"}, fu_rs1_o, a);
      chk({tag, "_c2_shb"}, fu_shareB_o, rw[7:0]);
      chk({tag, "_c2_rnd"}, fu_rand_o, rw[43:8]);
      chk({tag, "_c2_resv"}, res_valid_o, 0);
      step();                                         // cycle 3: DONE
      chk({tag, "_c3_resv"}, res_valid_o, 1);
      chk({tag, "_c3_fuv"}, fu_valid_o, 0);
      chk({tag, "_c3_rd"}, res_rd_o, exp_rd);
      res_ready_i = 1'b1;
      step();
      res_ready_i = 1'b0;
      chk({tag, "_end_resv"}, res_valid_o, 0);
      post_end(tag);
   endtask

   initial begin
      reset = 1'b1; op_valid_i = 1'b0; op_kind_i = 2'd0; rs1_i = '0; rs2_i = '0;
      bs_i = '0; kill_i = 1'b0; rng_valid_i = 1'b0; rng_data_i = '0;
      res_ready_i = 1'b0;
      step(); step();
      reset = 1'b0;
      step();

      // reset state
      chk("rst_rdy", op_ready_o, 1);
      chk("rst_req", rng_req_o, 0);
      chk("rst_fuv", fu_valid_o, 0);
      chk("rst_resv", res_valid_o, 0);
      chk("rst_op", fu_op_o, 0);
      chk("rst_rs1", fu_rs1_o, 0);
      chk("rst_res", res_rd_o, 0);

      // single encsm, reference result
      run_op("encsm", 2'd1, 32'h0, 32'h00000053, 2'd0, 44'h0F0F0F0F0F5, 4'b0010,
             32'hED76769B);

      // RNG stall: 5 RNG cycles without a word, result at accept + 3 + 5
      present(2'd0, 32'h11223344, 32'h55667788, 2'd2);
      rng_valid_i = 1'b0; rng_data_i = 44'hFFFFFFFFFFF;
      step();
      op_valid_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("stall_req", rng_req_o, 1);
         chk("stall_fuv", fu_valid_o, 0);
         chk("stall_resv", res_valid_o, 0);
         step();
      end
      chk("stall_req_last", rng_req_o, 1);
      rng_valid_i = 1'b1; rng_data_i = 44'hABCDEF01234;
      step();
      rng_valid_i = 1'b0;
      chk("stall_fuv_on", fu_valid_o, 1);
      chk("stall_op", fu_op_o, 4'b0001);
      chk("stall_bs", fu_bs_o, 2'd2);
      chk("stall_shb", fu_shareB_o, 8'h34);
      chk("stall_rnd", fu_rand_o, 36'hABCDEF012);
      step();
      chk("stall_resv_on", res_valid_o, 1);
      chk("stall_rd", res_rd_o, 32'h66AA6603);
      res_ready_i = 1'b1;
      step();
      res_ready_i = 1'b0;
      post_end("stall");

      // result backpressure: 4 cycles in DONE with a new op already waiting
      present(2'd2, 32'h0, 32'h000000FF, 2'd1);
      rng_valid_i = 1'b1; rng_data_i = 44'h123456789AB;
      step(); step();
      rng_valid_i = 1'b0;
      chk("bp_shb", fu_shareB_o, 8'hAB);
      chk("bp_rnd", fu_rand_o, 36'h123456789);
      chk("bp_op", fu_op_o, 4'b0100);
      step();
      for (int i = 0; i < 4; i++) begin
         chk("bp_resv", res_valid_o, 1);
         chk("bp_rd", res_rd_o, 32'h00FF0014);
         chk("bp_rdy", op_ready_o, 0);
         chk("bp_req", rng_req_o, 0);
         step();
      end
      res_ready_i = 1'b1;                 // op_valid_i still high here
      step();
      res_ready_i = 1'b0;
      chk("bp_hs_resv", res_valid_o, 0);
      chk("bp_hs_noacc", rng_req_o, 0);   // nothing accepted in handshake cycle
      op_valid_i = 1'b0;
      post_end("bp");
      step();

      // kill in first EXEC cycle, then a normal op
      present(2'd0, 32'hA5A5A5A5, 32'h0, 2'd0);
      rng_valid_i = 1'b1; rng_data_i = 44'h00000000001;
      step();
      op_valid_i = 1'b0;
      step();
      rng_valid_i = 1'b0;
      chk("kill_in_exec", fu_valid_o, 1);
      kill_i = 1'b1;
      step();
      kill_i = 1'b0;
      chk("kill_fuv", fu_valid_o, 0);
      chk("kill_resv", res_valid_o, 0);
      post_end("kill");
      for (int i = 0; i < 3; i++) begin
         chk("kill_no_res", res_valid_o, 0);
         step();
      end
      run_op("after_kill", 2'd1, 32'h000000FF, 32'h00000053, 2'd0, 44'h55555555555,
             4'b0010, 32'hED767664);

      // kill together with the RNG word: word dropped, no EXEC
      present(2'd3, 32'h1, 32'h2, 2'd3);
      rng_valid_i = 1'b0;
      step();
      op_valid_i = 1'b0;
      kill_i = 1'b1; rng_valid_i = 1'b1; rng_data_i = 44'h77777777777;
      step();
      kill_i = 1'b0; rng_valid_i = 1'b0;
      chk("krng_fuv", fu_valid_o, 0);
      chk("krng_req", rng_req_o, 0);
      chk("krng_shb", (fu_shareB_o == 8'h77), 0);
      post_end("krng");

      // reset during EXEC
      present(2'd3, 32'hCAFEF00D, 32'h12345678, 2'd1);
      rng_valid_i = 1'b1; rng_data_i = 44'h3C3C3C3C3C3;
      step();
      op_valid_i = 1'b0;
      step();
      rng_valid_i = 1'b0;
      chk("mrst_exec", fu_valid_o, 1);
      chk("mrst_op", fu_op_o, 4'b1000);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mrst_rdy", op_ready_o, 1);
      chk("mrst_fuv", fu_valid_o, 0);
      chk("mrst_resv", res_valid_o, 0);
      chk("mrst_req", rng_req_o, 0);
      chk("mrst_op0", fu_op_o, 0);
      chk("mrst_rs1", fu_rs1_o, 0);
      chk("mrst_shb", fu_shareB_o, 0);
      chk("mrst_rnd", fu_rand_o, 0);
      chk("mrst_res", res_rd_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
